// File: rtl/branch_checkpoint_unit.sv
// branch_checkpoint_unit: branch checkpoint table with misprediction recovery sequencer
module branch_checkpoint_unit #(
  parameter int BRANCH_NUM    = 4,
  parameter int AL_SIZE       = 64,
  parameter int PREG_NUM      = 128,
  parameter int AREG_NUM      = 32,
  parameter int RESTORE_LANES = 8,
  localparam int BR_W   = $clog2(BRANCH_NUM),
  localparam int AL_W   = $clog2(AL_SIZE),
  localparam int PREG_W = $clog2(PREG_NUM),
  localparam int AREG_W = $clog2(AREG_NUM),
  localparam int MAP_W  = AREG_NUM * PREG_W,
  localparam int SL_W   = RESTORE_LANES * PREG_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              alloc_valid,
  input  logic [AL_W-1:0]   alloc_al_id,
  input  logic              alloc_color,
  input  logic              alloc_ds,
  input  logic [PREG_W-1:0] alloc_free_head,
  input  logic [MAP_W-1:0]  alloc_map,
  output logic              alloc_ready,
  output logic [BR_W-1:0]   alloc_tag,
  input  logic              resolve_valid,
  input  logic [BR_W-1:0]   resolve_tag,
  input  logic              miss_valid,
  input  logic [BR_W-1:0]   miss_tag,
  output logic [BRANCH_NUM-1:0] entry_valid,
  output logic              busy,
  output logic              squash_valid,
  output logic [AL_W-1:0]   squash_al_id,
  output logic              squash_color,
  output logic [PREG_W-1:0] restore_free_head,
  output logic [AL_W-1:0]   restore_youngest,
  output logic              restore_global_color,
  output logic              map_wr_valid,
  output logic [AREG_W-1:0] map_wr_base,
  output logic [SL_W-1:0]   map_wr_data
);
  localparam int R  = AREG_NUM / RESTORE_LANES;
  localparam int CW = R > 1 ? $clog2(R) : 1;
  localparam logic [0:0] IDLE    = 1'b0;
  localparam logic [0:0] RESTORE = 1'b1;
  logic [BRANCH_NUM-1:0] valid, valid_nxt, kill;
  logic [BR_W-1:0]       tail;
  logic [AL_W-1:0]       e_al_id [BRANCH_NUM];
  logic [PREG_W-1:0]     e_free_head [BRANCH_NUM];
  logic [MAP_W-1:0]      e_map [BRANCH_NUM];
  logic [BRANCH_NUM-1:0] e_color, e_ds;
  logic [0:0]            state;
  logic [CW-1:0]         c;
  logic [MAP_W-1:0]      saved_map;
  logic [AL_W-1:0]       cur_al_id;
  logic                  cur_color;
  logic                  alloc_fire, miss_acc, new_older, b_color;
  logic [AL_W:0]         b_sum;
  logic [AL_W-1:0]       b;
  assign busy         = state == RESTORE;
  assign alloc_ready  = !busy && !valid[tail] && !miss_valid;
  assign alloc_fire   = alloc_valid && alloc_ready;
  assign alloc_tag    = tail;
  assign entry_valid  = valid;
  assign new_older    = (e_color[miss_tag] == cur_color) ? e_al_id[miss_tag] < cur_al_id
                                                         : e_al_id[miss_tag] > cur_al_id;
  assign miss_acc     = miss_valid && valid[miss_tag] && (!busy || new_older);
  assign b_sum        = {1'b0, e_al_id[miss_tag]} + (AL_W+1)'(e_ds[miss_tag]);
  assign b            = b_sum[AL_W-1:0];
  assign b_color      = e_color[miss_tag] ^ b_sum[AL_W];
  assign map_wr_valid = busy;
  assign map_wr_base  = busy ? AREG_W'(32'(c) * RESTORE_LANES) : '0;
  assign map_wr_data  = busy ? saved_map[32'(c) * SL_W +: SL_W] : '0;
  // next valid bits: allocate, then resolve, then kill the missed branch and everything younger
  always_comb begin
    kill = '0;
    for (int i = 0; i < BRANCH_NUM; i++)
      kill[i] = BR_W'(BR_W'(i) - miss_tag) <= BR_W'(tail - miss_tag - BR_W'(1));
    valid_nxt = valid;
    if (alloc_fire) valid_nxt[tail] = 1'b1;
    if (resolve_valid) valid_nxt[resolve_tag] = 1'b0;
    valid_nxt = miss_acc ? valid_nxt & ~kill : valid_nxt;
  end
  // control state, squash broadcast and restore sequencing
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      valid                <= '0;
      tail                 <= '0;
      state                <= IDLE;
      c                    <= '0;
      cur_al_id            <= '0;
      cur_color            <= 1'b0;
      squash_valid         <= 1'b0;
      squash_al_id         <= '0;
      squash_color         <= 1'b0;
      restore_free_head    <= '0;
      restore_youngest     <= '0;
      restore_global_color <= 1'b0;
    end else begin
      valid        <= valid_nxt;
      squash_valid <= miss_acc;
      if (miss_acc) begin
        tail                 <= miss_tag + BR_W'(1);
        state                <= RESTORE;
        c                    <= '0;
        cur_al_id            <= e_al_id[miss_tag];
        cur_color            <= e_color[miss_tag];
        squash_al_id         <= b;
        squash_color         <= b_color;
        restore_free_head    <= e_free_head[miss_tag];
        restore_youngest     <= b + AL_W'(1);
        restore_global_color <= b_color ^ (b == AL_W'(AL_SIZE - 1));
      end else begin
        if (alloc_fire) tail <= tail + BR_W'(1);
        if (busy) begin
          state <= (c == CW'(R - 1)) ? IDLE : RESTORE;
          c     <= c + CW'(1);
        end
      end
    end
  end
  // checkpoint payload storage and the map snapshot being streamed back
  always_ff @(posedge clk) begin
    if (alloc_fire) begin
      e_al_id[tail]     <= alloc_al_id;
      e_color[tail]     <= alloc_color;
      e_ds[tail]        <= alloc_ds;
      e_free_head[tail] <= alloc_free_head;
      e_map[tail]       <= alloc_map;
    end
    if (miss_acc) saved_map <= e_map[miss_tag];
  end
endmodule
